// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encodings,
// load/store size codes and the size-to-byte-count helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Number of byte transfers for a load/store size code; code 3 acts as a word.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Byte-lane datapath for the memory port arbiter: collects read bytes into a
// little-endian word and picks the store byte for the current byte index.
module mem_byte_assembler #(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           i_rst_n,
    input  logic           i_clr,
    input  logic           i_cap,
    input  logic [7:0]     i_din,
    input  logic [2:0]     i_n,
    input  logic [2:0]     i_k,
    input  logic [LEN-1:0] i_wdata,
    output logic [LEN-1:0] o_word,
    output logic [7:0]     o_wbyte
);

    logic [LEN-1:0] r_shift;
    logic [LEN-1:0] w_next;

    // Newest byte enters at the top so byte 0 ends up lowest after N shifts.
    always_comb begin
        w_next = i_cap ? {i_din, r_shift[LEN-1:8]} : r_shift;
    end

    // Right-align the collected bytes; upper lanes fill with zeros.
    always_comb begin
        case (i_n)
            3'd1:    o_word = w_next >> (LEN - 8);
            3'd2:    o_word = w_next >> (LEN - 16);
            default: o_word = w_next;
        endcase
    end

    // Store byte for the current index.
    always_comb begin
        case (i_k)
            3'd0:    o_wbyte = i_wdata[7:0];
            3'd1:    o_wbyte = i_wdata[15:8];
            3'd2:    o_wbyte = i_wdata[23:16];
            3'd3:    o_wbyte = i_wdata[31:24];
            default: o_wbyte = 8'd0;
        endcase
    end

    // Shift register: cleared on a new transfer, shifts on each captured byte.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_shift <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
        end else if (i_cap) begin
            r_shift <= w_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the byte-wide RAM port between instruction fetch and the
// load/store unit. Multi-byte accesses run as consecutive byte transfers.
// Optional build macro MEM_PORT_ARBITER_RR_EN selects round-robin arbitration
// instead of fixed load/store priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_in,
    input  logic                  if_req,
    input  logic [LEN-1:0]        if_addr,
    output logic                  if_done,
    output logic [LEN-1:0]        if_inst,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [1:0]            ls_size,
    input  logic [LEN-1:0]        ls_addr,
    input  logic [LEN-1:0]        ls_wdata,
    output logic                  ls_done,
    output logic [LEN-1:0]        ls_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    output logic                  busy
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [2:0]            r_n;
    logic [2:0]            r_k;
    logic                  r_pend;
    logic [LEN-1:0]        r_wdata;
    logic                  r_if_done;
    logic                  r_ls_done;
    logic [LEN-1:0]        r_if_inst;
    logic [LEN-1:0]        r_ls_rdata;

    logic                  w_if_elig;
    logic                  w_ls_elig;
    logic                  w_grant_ls;
    logic                  w_accept;
    logic [LEN-1:0]        w_word;
    logic [7:0]            w_wbyte;
    logic                  w_unused;

    assign w_if_elig = if_req && !r_if_done;
    assign w_ls_elig = ls_req && !r_ls_done;
    assign w_accept  = rdy_in && (r_state == IDLE) && (w_if_elig || w_ls_elig);
    assign w_unused  = &{1'b0, if_addr[LEN-1:ADDR_WIDTH], ls_addr[LEN-1:ADDR_WIDTH]};

`ifdef MEM_PORT_ARBITER_RR_EN
    logic r_last_ls;

    // On a conflict the requester not granted last time wins.
    assign w_grant_ls = w_ls_elig && (!w_if_elig || !r_last_ls);

    // Remember who was granted at each acceptance; starts as IF so LS wins first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_ls <= 1'b0;
        end else if (w_accept) begin
            r_last_ls <= w_grant_ls;
        end
    end
`else
    // Fixed priority: load/store wins any conflict.
    assign w_grant_ls = w_ls_elig;
`endif

    mem_byte_assembler #(.LEN(LEN)) u_asm (
        .clk     (clk),
        .i_rst_n (rst),
        .i_clr   (w_accept),
        .i_cap   (r_pend),
        .i_din   (mem_din),
        .i_n     (r_n),
        .i_k     (r_k),
        .i_wdata (r_wdata),
        .o_word  (w_word),
        .o_wbyte (w_wbyte)
    );

    assign mem_a    = (r_state == IDLE) ? '0 : r_base + ADDR_WIDTH'(r_k);
    assign mem_wr   = (r_state == LS_WR) && rdy_in;
    assign mem_dout = (r_state == LS_WR) ? w_wbyte : 8'd0;
    assign busy     = (r_state != IDLE);
    assign if_done  = r_if_done;
    assign ls_done  = r_ls_done;
    assign if_inst  = r_if_inst;
    assign ls_rdata = r_ls_rdata;

    // Transfer FSM: arbitration, byte counter and registered done/data outputs.
    // r_pend marks a read byte in flight; it is captured even on a paused edge
    // so the RAM's one-cycle output is never lost, but only addresses issued on
    // a ready edge advance the counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_pend     <= 1'b0;
            r_wdata    <= '0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_inst  <= '0;
            r_ls_rdata <= '0;
        end else begin
            r_pend <= 1'b0;
            if (rdy_in) begin
                case (r_state)
                    IDLE: begin
                        r_if_done <= 1'b0;
                        r_ls_done <= 1'b0;
                        if (w_accept) begin
                            r_k <= 3'd0;
                            if (w_grant_ls) begin
                                r_base  <= ls_addr[ADDR_WIDTH-1:0];
                                r_n     <= size_to_n(ls_size);
                                r_wdata <= ls_wdata;
                                r_state <= ls_we ? LS_WR : LS_RD;
                            end else begin
                                r_base  <= if_addr[ADDR_WIDTH-1:0];
                                r_n     <= 3'd4;
                                r_state <= IF_RD;
                            end
                        end
                    end
                    IF_RD, LS_RD: begin
                        if (r_k < r_n) begin
                            r_k    <= r_k + 3'd1;
                            r_pend <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            if (r_state == IF_RD) begin
                                r_if_done <= 1'b1;
                                r_if_inst <= w_word;
                            end else begin
                                r_ls_done  <= 1'b1;
                                r_ls_rdata <= w_word;
                            end
                        end
                    end
                    LS_WR: begin
                        r_k <= r_k + 3'd1;
                        if ((r_k + 3'd1) == r_n) begin
                            r_state   <= IDLE;
                            r_ls_done <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy_in = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_inst;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [16:0] mem_a;
    logic        mem_wr;
    logic        busy;

    logic [7:0]  ram [0:131071];
    int          total = 0;
    int          bad = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a] <= mem_dout;
        mem_din <= ram[mem_a];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the selected done pulse, returning ticks taken.
    task automatic wait_done(input bit sel_ls, output int cyc);
        cyc = 0;
        while (cyc < 40 && !(sel_ls ? ls_done : if_done)) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total++; if (if_done !== 1'b0) begin bad++; $display("FAIL reset_if_done got=%b want=0", if_done); end
        total++; if (ls_done !== 1'b0) begin bad++; $display("FAIL reset_ls_done got=%b want=0", ls_done); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%b want=0", mem_wr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (mem_a !== 17'h0) begin bad++; $display("FAIL reset_mem_a got=%h want=0", mem_a); end
        total++; if (mem_dout !== 8'h0) begin bad++; $display("FAIL reset_mem_dout got=%h want=0", mem_dout); end
        total++; if (if_inst !== 32'h0) begin bad++; $display("FAIL reset_if_inst got=%h want=0", if_inst); end
        total++; if (ls_rdata !== 32'h0) begin bad++; $display("FAIL reset_ls_rdata got=%h want=0", ls_rdata); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_conflict();
        int cyc;
        logic [16:0] win_a;
        logic [16:0] lose_a;
        bit win_ls;
        // Phase A: first conflict after reset goes to LS in both builds.
        if_addr = 32'h200; ls_addr = 32'h300; ls_size = 2'd2; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        tick();
        total++; if (mem_a !== 17'h300) begin bad++; $display("FAIL conflictA_first_addr got=%h want=300", mem_a); end
        wait_done(1'b1, cyc);
        total++; if (cyc !== 5) begin bad++; $display("FAIL conflictA_latency got=%0d want=5", cyc); end
        total++; if (ls_rdata !== 32'hD4C3B2A1) begin bad++; $display("FAIL conflictA_rdata got=%h want=d4c3b2a1", ls_rdata); end
        total++; if (if_done !== 1'b0) begin bad++; $display("FAIL conflictA_if_done got=%b want=0", if_done); end
        if_req = 1'b0; ls_req = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL conflictA_idle got=%b want=0", busy); end
        // Phase B: second conflict.
`ifdef MEM_PORT_ARBITER_RR_EN
        win_ls = 1'b0; win_a = 17'h200; lose_a = 17'h300;
`else
        win_ls = 1'b1; win_a = 17'h300; lose_a = 17'h200;
`endif
        if_req = 1'b1; ls_req = 1'b1;
        tick();
        total++; if (mem_a !== win_a) begin bad++; $display("FAIL conflictB_winner got=%h want=%h", mem_a, win_a); end
        wait_done(win_ls, cyc);
        total++; if (cyc !== 5) begin bad++; $display("FAIL conflictB_latency got=%0d want=5", cyc); end
        if (win_ls) ls_req = 1'b0; else if_req = 1'b0;
        tick();
        total++; if (mem_a !== lose_a || busy !== 1'b1) begin bad++; $display("FAIL conflictB_back_to_back got=%h/%b want=%h/1", mem_a, busy, lose_a); end
        wait_done(!win_ls, cyc);
        total++; if (cyc !== 5) begin bad++; $display("FAIL conflictB_loser_latency got=%0d want=5", cyc); end
        total++; if (if_inst !== 32'h44332211) begin bad++; $display("FAIL conflictB_if_inst got=%h want=44332211", if_inst); end
        total++; if (ls_rdata !== 32'hD4C3B2A1) begin bad++; $display("FAIL conflictB_ls_rdata got=%h want=d4c3b2a1", ls_rdata); end
        if_req = 1'b0; ls_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_if_word();
        logic [16:0] exp_a;
        if_addr = 32'hFFFE_0100;
        if_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            exp_a = 17'h100 + 17'(c - 1);
            total++;
            if (mem_a !== exp_a || mem_wr !== 1'b0 || if_done !== 1'b0) begin
                bad++;
                $display("FAIL if_word_cycle%0d got a=%h wr=%b done=%b want a=%h wr=0 done=0", c, mem_a, mem_wr, if_done, exp_a);
            end
        end
        tick();
        total++; if (if_done !== 1'b0) begin bad++; $display("FAIL if_word_early_done got=%b want=0", if_done); end
        tick();
        total++; if (if_done !== 1'b1) begin bad++; $display("FAIL if_word_done got=%b want=1", if_done); end
        total++; if (if_inst !== 32'h00000513) begin bad++; $display("FAIL if_word_inst got=%h want=00000513", if_inst); end
        if_req = 1'b0;
        tick();
        total++; if (if_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL if_word_single_pulse got=%b/%b want=0/0", if_done, busy); end
        total++; if (if_inst !== 32'h00000513) begin bad++; $display("FAIL if_word_hold got=%h want=00000513", if_inst); end
    endtask

    task automatic test_ls_byte_store();
        ls_addr = 32'h0001FFFF; ls_size = 2'd0; ls_we = 1'b1; ls_wdata = 32'h123456AB;
        ls_req = 1'b1;
        tick();
        total++;
        if (mem_wr !== 1'b1 || mem_a !== 17'h1FFFF || mem_dout !== 8'hAB || ls_done !== 1'b0) begin
            bad++;
            $display("FAIL store_byte_cycle1 got wr=%b a=%h d=%h done=%b want 1/1ffff/ab/0", mem_wr, mem_a, mem_dout, ls_done);
        end
        rdy_in = 1'b0;
        #1;
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL store_rdy_gate got=%b want=0", mem_wr); end
        rdy_in = 1'b1;
        #1;
        tick();
        total++; if (ls_done !== 1'b1 || mem_wr !== 1'b0) begin bad++; $display("FAIL store_byte_done got=%b/%b want=1/0", ls_done, mem_wr); end
        ls_req = 1'b0; ls_we = 1'b0;
        tick();
        total++; if (ram[17'h1FFFF] !== 8'hAB) begin bad++; $display("FAIL store_byte_ram got=%h want=ab", ram[17'h1FFFF]); end
        total++; if (if_inst !== 32'h00000513) begin bad++; $display("FAIL store_if_inst_hold got=%h want=00000513", if_inst); end
    endtask

    task automatic test_half_load_wrap();
        int cyc;
        ram[17'h1FFFF] <= 8'h34;
        ram[17'h00000] <= 8'h12;
        ls_addr = 32'h0001FFFF; ls_size = 2'd1; ls_we = 1'b0;
        ls_req = 1'b1;
        tick();
        total++; if (mem_a !== 17'h1FFFF) begin bad++; $display("FAIL half_addr0 got=%h want=1ffff", mem_a); end
        tick();
        total++; if (mem_a !== 17'h00000) begin bad++; $display("FAIL half_addr_wrap got=%h want=0", mem_a); end
        wait_done(1'b1, cyc);
        total++; if (cyc !== 2) begin bad++; $display("FAIL half_latency got=%0d want=2", cyc); end
        total++; if (ls_rdata !== 32'h00001234) begin bad++; $display("FAIL half_rdata got=%h want=00001234", ls_rdata); end
        ls_req = 1'b0;
        tick();
    endtask

    task automatic test_rdy_pause();
        int cyc;
        if_addr = 32'h200;
        if_req = 1'b1;
        tick();
        tick();
        tick();
        total++; if (mem_a !== 17'h202) begin bad++; $display("FAIL pause_addr2 got=%h want=202", mem_a); end
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (mem_a !== 17'h202 || mem_wr !== 1'b0 || if_done !== 1'b0) begin
                bad++;
                $display("FAIL pause_hold%0d got a=%h wr=%b done=%b want 202/0/0", i, mem_a, mem_wr, if_done);
            end
        end
        rdy_in = 1'b1;
        wait_done(1'b0, cyc);
        total++; if (cyc !== 3) begin bad++; $display("FAIL pause_done_delay got=%0d want=3", cyc); end
        total++; if (if_inst !== 32'h44332211) begin bad++; $display("FAIL pause_inst got=%h want=44332211", if_inst); end
        if_req = 1'b0;
        rdy_in = 1'b0;
        tick();
        total++; if (if_done !== 1'b1) begin bad++; $display("FAIL pause_done_stretch1 got=%b want=1", if_done); end
        tick();
        total++; if (if_done !== 1'b1) begin bad++; $display("FAIL pause_done_stretch2 got=%b want=1", if_done); end
        rdy_in = 1'b1;
        tick();
        total++; if (if_done !== 1'b0) begin bad++; $display("FAIL pause_done_clear got=%b want=0", if_done); end
    endtask

    task automatic test_reset_midstore();
        int cyc;
        ls_addr = 32'h400; ls_size = 2'd2; ls_we = 1'b1; ls_wdata = 32'hCAFEF00D;
        ls_req = 1'b1;
        tick();
        total++; if (mem_wr !== 1'b1 || mem_a !== 17'h400 || mem_dout !== 8'h0D) begin bad++; $display("FAIL midrst_byte0 got %b/%h/%h want 1/400/0d", mem_wr, mem_a, mem_dout); end
        tick();
        total++; if (mem_wr !== 1'b1 || mem_a !== 17'h401 || mem_dout !== 8'hF0) begin bad++; $display("FAIL midrst_byte1 got %b/%h/%h want 1/401/f0", mem_wr, mem_a, mem_dout); end
        rst = 1'b0;
        tick();
        total++; if (mem_wr !== 1'b0 || busy !== 1'b0 || ls_done !== 1'b0) begin bad++; $display("FAIL midrst_abort got wr=%b busy=%b done=%b want 0/0/0", mem_wr, busy, ls_done); end
        rst = 1'b1;
        ls_req = 1'b0; ls_we = 1'b0;
        tick();
        total++; if (ls_done !== 1'b0) begin bad++; $display("FAIL midrst_no_done1 got=%b want=0", ls_done); end
        tick();
        total++; if (ls_done !== 1'b0) begin bad++; $display("FAIL midrst_no_done2 got=%b want=0", ls_done); end
        total++; if (ram[17'h402] !== 8'h5A) begin bad++; $display("FAIL midrst_no_write2 got=%h want=5a", ram[17'h402]); end
        total++; if (ram[17'h400] !== 8'h0D) begin bad++; $display("FAIL midrst_write0 got=%h want=0d", ram[17'h400]); end
        ls_addr = 32'h400; ls_size = 2'd0; ls_we = 1'b0;
        ls_req = 1'b1;
        wait_done(1'b1, cyc);
        total++; if (cyc !== 3) begin bad++; $display("FAIL midrst_after_latency got=%0d want=3", cyc); end
        total++; if (ls_rdata !== 32'h0000000D) begin bad++; $display("FAIL midrst_after_rdata got=%h want=0000000d", ls_rdata); end
        ls_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) ram[i] <= 8'h00;
        ram[17'h100] <= 8'h13; ram[17'h101] <= 8'h05;
        ram[17'h102] <= 8'h00; ram[17'h103] <= 8'h00;
        ram[17'h200] <= 8'h11; ram[17'h201] <= 8'h22;
        ram[17'h202] <= 8'h33; ram[17'h203] <= 8'h44;
        ram[17'h300] <= 8'hA1; ram[17'h301] <= 8'hB2;
        ram[17'h302] <= 8'hC3; ram[17'h303] <= 8'hD4;
        ram[17'h402] <= 8'h5A;
        test_reset();
        test_conflict();
        test_if_word();
        test_ls_byte_store();
        test_half_load_wrap();
        test_rdy_pause();
        test_reset_midstore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
